// File: rtl/fb_ops_ctrl.sv
// Command engine and RAM port arbiter for the 80x25 text framebuffer.
// Define FB_OPS_FAIR_EN for round-robin host/engine arbitration (default: host priority).
module fb_ops_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 25,
    parameter int AW   = 11,
    parameter int DW   = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_fill,
    output logic          cmd_ready,
    output logic          busy,
    output logic          done,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [AW-1:0] COLS_A = AW'(COLS);
    localparam logic [AW-1:0] LAST_A = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] LROW_A = AW'(COLS * (ROWS - 1));

    typedef enum logic [2:0] {
        IDLE, CLR, SC_RD, SC_CAP, SC_WR, SC_FL, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          done_q, done_d;
    logic          rvalid_q, rvalid_d;
    logic          eng_req, eng_gnt;

`ifdef FB_OPS_FAIR_EN
    logic          last_host_q, last_host_d;
`endif

    // Arbitration: decide who owns the RAM port this cycle.
    always_comb begin
        eng_req = (state_q == CLR) || (state_q == SC_RD) ||
                  (state_q == SC_WR) || (state_q == SC_FL);
`ifdef FB_OPS_FAIR_EN
        h_gnt = !rst && h_req && (!eng_req || !last_host_q);
`else
        h_gnt = !rst && h_req;
`endif
        eng_gnt = eng_req && !h_gnt;
    end

    // RAM port mux driven by the winner; idle port is all zeros.
    always_comb begin
        m_addr  = '0;
        m_we    = 1'b0;
        m_wdata = '0;
        if (h_gnt) begin
            m_addr  = h_addr;
            m_we    = h_we;
            m_wdata = h_wdata;
        end else if (eng_gnt) begin
            case (state_q)
                CLR, SC_FL: begin
                    m_addr  = cnt_q;
                    m_we    = 1'b1;
                    m_wdata = fill_q;
                end
                SC_RD: begin
                    m_addr = cnt_q + COLS_A;
                end
                SC_WR: begin
                    m_addr  = cnt_q;
                    m_we    = 1'b1;
                    m_wdata = hold_q;
                end
                default: ;
            endcase
        end
    end

    // Command FSM next-state; engine stalls whenever it is not granted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        rvalid_d = h_gnt && !h_we;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    fill_d = cmd_fill;
                    cnt_d  = '0;
                    case (cmd_op)
                        2'd1:    state_d = CLR;
                        2'd2:    state_d = SC_RD;
                        default: state_d = FIN;
                    endcase
                end
            end
            CLR, SC_FL: begin
                if (eng_gnt) begin
                    if (cnt_q == LAST_A) begin
                        cnt_d   = '0;
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            SC_RD: begin
                if (eng_gnt) state_d = SC_CAP;
            end
            SC_CAP: begin
                hold_d  = m_rdata;
                state_d = SC_WR;
            end
            SC_WR: begin
                if (eng_gnt) begin
                    cnt_d   = cnt_q + AW'(1);
                    state_d = (cnt_q + AW'(1) == LROW_A) ? SC_FL : SC_RD;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            fill_q   <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef FB_OPS_FAIR_EN
    // Remember which side used the port last so contention alternates.
    always_comb begin
        last_host_d = last_host_q;
        if (h_gnt)        last_host_d = 1'b1;
        else if (eng_gnt) last_host_d = 1'b0;
    end

    // Round-robin history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_host_q <= 1'b0;
        else     last_host_q <= last_host_d;
    end
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign h_rvalid  = rvalid_q;
    assign h_rdata   = m_rdata;

endmodule

// File: tb/tb_fb_ops_ctrl.sv
// Scoreboard bench for fb_ops_ctrl with a behavioural RAM and framebuffer model.
// Host read data and done latencies are queued at issue and checked by a monitor.
module tb_fb_ops_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int AW    = 11;
    localparam int DW    = 9;
    localparam int CELLS = COLS * ROWS;
    localparam int LROW  = COLS * (ROWS - 1);
`ifdef FB_OPS_FAIR_EN
    localparam int MAXW  = 1;
`else
    localparam int MAXW  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_fill;
    logic          cmd_ready, busy, done;
    logic          h_req, h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt, h_rvalid;
    logic [DW-1:0] h_rdata;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    fb_ops_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
        .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:2047];
    always @(posedge clk) begin
        if (m_we) ram[m_addr] <= m_wdata;
        m_rdata <= ram[m_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t0;
        int min;
        bit exact;
    } dexp_t;

    dexp_t         dq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] exp_mem [0:CELLS-1];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares DUT responses against queued expectations.
    initial begin : monitor
        bit prev_done;
        dexp_t e;
        logic [DW-1:0] r;
        int lat;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (h_rvalid) begin
                    check("rvalid_expected", int'(rq.size() > 0), 1);
                    if (rq.size() > 0) begin
                        r = rq.pop_front();
                        check("host_rdata", int'(h_rdata), int'(r));
                    end
                end
                if (done) begin
                    check("done_single_cycle", int'(prev_done), 0);
                    check("done_expected", int'(dq.size() > 0), 1);
                    if (dq.size() > 0) begin
                        e = dq.pop_front();
                        lat = cyc - e.t0;
                        if (e.exact) check("done_latency", lat, e.min);
                        else check("done_latency_min", int'(lat >= e.min), 1);
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic host_op(input bit we, input int addr,
                           input logic [DW-1:0] data, output int waits);
        h_req   = 1'b1;
        h_we    = we;
        h_addr  = AW'(addr);
        h_wdata = data;
        waits   = 0;
        #1;
        while (!h_gnt && waits < 200) begin
            @(negedge clk);
            #2;
            waits++;
        end
        if (h_gnt) begin
            if (we) exp_mem[addr] = data;
            else rq.push_back(exp_mem[addr]);
        end else begin
            check("host_grant_timeout", waits, 0);
        end
        @(negedge clk);
        #1;
        h_req = 1'b0;
        h_we  = 1'b0;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [DW-1:0] fill,
                             input int min, input bit exact);
        dexp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_fill  = fill;
        check("cmd_ready_at_issue", int'(cmd_ready), 1);
        e.t0 = cyc;
        e.min = min;
        e.exact = exact;
        dq.push_back(e);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (dq.size() > 0 && n < 20000) begin
            tick();
            n++;
        end
        check("command_completes", dq.size(), 0);
    endtask

    task automatic model_clear(input logic [DW-1:0] fill);
        for (int k = 0; k < CELLS; k++) exp_mem[k] = fill;
    endtask

    task automatic model_scroll(input logic [DW-1:0] fill);
        for (int k = 0; k < LROW; k++) exp_mem[k] = exp_mem[k + COLS];
        for (int k = LROW; k < CELLS; k++) exp_mem[k] = fill;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int k = 0; k < CELLS; k++)
            if (ram[k] !== exp_mem[k]) bad++;
        check(name, bad, 0);
    endtask

    task automatic preload(input bit rnd);
        int w;
        for (int k = 0; k < CELLS; k++)
            host_op(1'b1, k, rnd ? DW'($urandom) : DW'(k), w);
    endtask

    initial begin : stim
        int w, hg, ew, gap;
        logic [DW-1:0] f, v;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_fill = '0;
        h_req = 1'b1; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        tick(); tick();
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_h_gnt", int'(h_gnt), 0);
        check("rst_m_we", int'(m_we), 0);
        check("rst_m_addr", int'(m_addr), 0);
        check("rst_h_rvalid", int'(h_rvalid), 0);
        h_req = 1'b0;
        rst = 1'b0;
        tick(); tick();

        // NOP and reserved op: busy one cycle, then done.
        issue_cmd(2'd0, '0, 2, 1'b1);
        check("nop_busy", int'(busy), 1);
        wait_done();
        issue_cmd(2'd3, '0, 2, 1'b1);
        wait_done();

        // CLEAR with space fill.
        issue_cmd(2'd1, 9'h020, 2002, 1'b1);
        wait_done();
        model_clear(9'h020);
        check_mem("clear_contents");

        // Preload k, then idle-host scroll with zero fill.
        preload(1'b0);
        check_mem("preload_contents");
        for (int i = 0; i < 6; i++) host_op(1'b0, $urandom_range(0, CELLS - 1), '0, w);
        issue_cmd(2'd2, '0, 5842, 1'b1);
        model_scroll('0);
        wait_done();
        check_mem("scroll_contents");

        // Random preload, scroll with host traffic at address 5.
        preload(1'b1);
        f = DW'($urandom);
        v = exp_mem[COLS + 5];
        issue_cmd(2'd2, f, 5842, 1'b0);
        model_scroll(f);
        for (int i = 0; i < 40; i++) begin
            host_op(1'b1, 5, v, w);
            check("host_wait_wr", int'(w <= MAXW), 1);
            tick();
            host_op(1'b0, 5, '0, w);
            check("host_wait_rd", int'(w <= MAXW), 1);
            gap = $urandom_range(1, 20);
            for (int g = 0; g < gap; g++) tick();
        end
        wait_done();
        check_mem("scroll_with_host");

        // Continuous host request during CLEAR.
        f = DW'($urandom);
        issue_cmd(2'd1, f, 2002, 1'b0);
        tick(); tick();
        h_req = 1'b1; h_we = 1'b1; h_addr = AW'(CELLS - 1); h_wdata = f;
        hg = 0; ew = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            hg += int'(h_gnt);
            ew += int'(m_we && !h_gnt);
            tick();
        end
        h_req = 1'b0; h_we = 1'b0;
`ifdef FB_OPS_FAIR_EN
        check("hold_host_grants", hg, 20);
        check("hold_engine_writes", ew, 20);
`else
        check("hold_host_grants", hg, 40);
        check("hold_engine_writes", ew, 0);
`endif
        wait_done();
        model_clear(f);
        check_mem("clear_under_host_hold");

        // SCROLL command while CLEAR busy is ignored.
        f = DW'($urandom);
        issue_cmd(2'd1, f, 2002, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_fill = ~f;
        check("busy_cmd_ready", int'(cmd_ready), 0);
        check("busy_flag", int'(busy), 1);
        tick();
        cmd_valid = 1'b0;
        wait_done();
        for (int i = 0; i < 10; i++) tick();
        model_clear(f);
        check_mem("clear_ignores_scroll");

        // Reset in the middle of a SCROLL, then a fresh CLEAR.
        issue_cmd(2'd2, DW'($urandom), 5842, 1'b1);
        gap = $urandom_range(100, 3000);
        for (int i = 0; i < gap; i++) tick();
        h_req = 1'b1; h_we = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_cmd_ready", int'(cmd_ready), 1);
        check("midrst_h_gnt", int'(h_gnt), 0);
        check("midrst_m_we", int'(m_we), 0);
        check("midrst_m_addr", int'(m_addr), 0);
        check("midrst_done", int'(done), 0);
        dq.delete();
        rq.delete();
        h_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        f = DW'($urandom);
        issue_cmd(2'd1, f, 2002, 1'b1);
        wait_done();
        model_clear(f);
        check_mem("clear_after_reset");

        for (int i = 0; i < 5; i++) tick();
        check("queues_drained", rq.size() + dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
